// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan scheduler for a 4-digit seven-segment display
// Ports: clk, rst (async active-high), en (scan enable), load_req/load_data (new 16-bit value),
//        bcd_out (active digit code to decoder), ssd_ctl (active-low digit enables),
//        frame_done (pulse on digit3->digit0 wrap), upd_ack (pulse when pending value is displayed).
// Optional build macro SSD_LZ_BLANK_EN enables leading-zero suppression.
module ssd_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 4,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load_req,
    input  logic [15:0] load_data,
    output logic [3:0]  bcd_out,
    output logic [3:0]  ssd_ctl,
    output logic        frame_done,
    output logic        upd_ack
);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       idx, idx_nx;
    logic [15:0]      pending, shadow, shadow_nx;
    logic             pend_vld, start, wrap, lz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 2'd0;
            pending    <= 16'h0;
            shadow     <= 16'h0;
            pend_vld   <= 1'b0;
            bcd_out    <= 4'h0;
            frame_done <= 1'b0;
            upd_ack    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            shadow     <= shadow_nx;
            frame_done <= wrap;
            upd_ack    <= start && (load_req || pend_vld);
            if (load_req && !start) begin
                pending  <= load_data;
                pend_vld <= 1'b1;
            end else if (start) begin
                pend_vld <= 1'b0;
            end
            // the code is latched only when entering BLANK so the decoder settles while dark
            if (state_nx == BLANK && state != BLANK)
                bcd_out <= shadow_nx[{idx_nx, 2'b00} +: 4];
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        idx_nx   = idx;
        start    = 1'b0;
        wrap     = 1'b0;
        if (state == IDLE) begin
            cnt_nx = '0;
            idx_nx = 2'd0;
            if (en) begin
                state_nx = BLANK;
                start    = 1'b1;
            end
        end else if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = 2'd0;
        end else if (state == BLANK && cnt == BLANK_LAST) begin
            state_nx = SHOW;
            cnt_nx   = '0;
        end else if (state == SHOW && cnt == SHOW_LAST) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            idx_nx   = idx + 2'd1;
            wrap     = idx == 2'd3;
            start    = idx == 2'd3;
        end
        // a load on the frame-start cycle bypasses the pending register
        shadow_nx = !start ? shadow : load_req ? load_data : pend_vld ? pending : shadow;
    end

    always_comb begin
`ifdef SSD_LZ_BLANK_EN
        lz = idx != 2'd0 && (shadow >> {idx, 2'b00}) == 16'h0;
`else
        lz = 1'b0;
`endif
        ssd_ctl = (state == SHOW && !lz) ? ~(4'b0001 << idx) : 4'b1111;
    end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: scoreboard bench for ssd_scan_ctrl against a frame-position reference model
module tb_ssd_scan_ctrl;
    localparam int SD = 8, DC = 2, SLOT = SD + DC, FRAME = 4 * SLOT;
    logic        clk = 0, rst = 1, en = 0, load_req = 0;
    logic [15:0] load_data = 16'h0;
    logic [3:0]  bcd_out, ssd_ctl;
    logic        frame_done, upd_ack;
    int          checks = 0, errors = 0;
    typedef struct packed {logic [3:0] ssd; logic [3:0] bcd; logic fd; logic ack;} exp_t;
    exp_t        q[$];
    bit          m_act, m_pv;
    int          m_pos;
    logic [15:0] m_shadow, m_pend;
    logic [3:0]  m_bcd;

    ssd_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYC(DC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .load_req(load_req), .load_data(load_data),
        .bcd_out(bcd_out), .ssd_ctl(ssd_ctl), .frame_done(frame_done), .upd_ack(upd_ack)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // model: position inside the frame decides digit and lit/dark; shadow changes only at frame start
    always @(posedge clk) begin
        bit   start, wrap, ack, lit;
        int   d;
        exp_t e;
        if (rst) begin
            m_act = 0; m_pos = 0; m_shadow = 0; m_pend = 0; m_pv = 0; m_bcd = 0;
        end else begin
            start = 0; wrap = 0; ack = 0;
            if (!m_act) begin
                if (en) begin m_act = 1; m_pos = 0; start = 1; end
            end else if (!en) m_act = 0;
            else begin
                m_pos++;
                if (m_pos == FRAME) begin m_pos = 0; start = 1; wrap = 1; end
            end
            if (start && load_req) begin m_shadow = load_data; m_pv = 0; ack = 1; end
            else if (start && m_pv) begin m_shadow = m_pend; m_pv = 0; ack = 1; end
            else if (load_req) begin m_pend = load_data; m_pv = 1; end
            d = m_pos / SLOT;
            lit = m_act && (m_pos % SLOT) >= DC;
`ifdef SSD_LZ_BLANK_EN
            if (d > 0 && (m_shadow >> (4 * d)) == 0) lit = 0;
`endif
            if (m_act) m_bcd = m_shadow[4*d +: 4];
            e.ssd = lit ? ~(4'b0001 << d) : 4'b1111;
            e.bcd = m_bcd;
            e.fd  = wrap;
            e.ack = ack;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && q.size() > 0) begin
            e = q.pop_front();
            check("ssd_ctl", ssd_ctl, e.ssd);
            check("bcd_out", bcd_out, e.bcd);
            check("frame_done", frame_done, e.fd);
            check("upd_ack", upd_ack, e.ack);
            check("ssd_onehot", 16'($countones(~ssd_ctl) <= 1), 16'd1);
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic load(logic [15:0] v);
        load_req = 1; load_data = v;
        tick();
        load_req = 0;
    endtask

    task automatic wait_pos(int p);
        for (int i = 0; i < 4 * FRAME && !(m_act && m_pos == p); i++) tick();
        check("wait_pos_timeout", 16'(m_act && m_pos == p), 16'd1);
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        check("rst_ssd_ctl", ssd_ctl, 4'b1111);
        check("rst_bcd_out", bcd_out, 4'h0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_upd_ack", upd_ack, 1'b0);
        q.delete();
        tick(2);
        rst = 0;
    endtask

    initial begin
        en = 1;
        tick(2);
        do_reset();
        tick(2 * FRAME);
        wait_pos(SLOT + 3);
        load(16'h1234);
        tick(FRAME + 5);
        wait_pos(2 * SLOT);
        load(16'hAAAA);
        tick(4);
        load(16'h5678);
        tick(FRAME);
        wait_pos(FRAME - 1);
        load(16'h9000);
        tick(FRAME);
        wait_pos(2 * SLOT + DC + 3);
        en = 0;
        tick(3);
        en = 1;
        tick(FRAME);
        load(16'h0045);
        tick(2 * FRAME);
        load(16'h0000);
        tick(2 * FRAME);
        wait_pos(DC + 2);
        tick();
        do_reset();
        tick(FRAME);
        for (int i = 0; i < 3000; i++) begin
            en = $urandom_range(0, 299) != 0;
            load_req = $urandom_range(0, 24) == 0;
            load_data = 16'($urandom);
            tick();
        end
        load_req = 0;
        en = 1;
        wait_pos(SLOT + DC + 1);
        do_reset();
        tick(FRAME);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
